// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants for the MIPS pipeline stages.
//   WB_REGWRITE / WB_MEMTOREG : bit positions inside the 4-bit WB control bundle
//   SZ_WORD / SZ_HALF / SZ_BYTE : memory access size codes (M_MemSize)
//   lane_mask() : byte-lane enable pattern for a given size and byte offset
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int WB_REGWRITE = 3;
    localparam int WB_MEMTOREG = 2;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    // Little-endian lane enables; the offset is expected to be already
    // aligned to the access size by the caller.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] mask;
        mask = 4'b1111;
        case (size)
            SZ_BYTE: mask = 4'b0001 << off;
            SZ_HALF: mask = 4'b0011 << off;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
// Word-organised data memory with four byte-lane write enables and an
// asynchronous (combinational) read port.
//   i_clk    : write clock, rising edge
//   i_addr   : word index
//   i_we     : per-byte-lane write enables (bit n -> bits [8n+7:8n])
//   i_wdata  : write data, already placed in its lanes
//   o_rdata  : current contents of the addressed word
// A write merges enabled lanes of i_wdata with the existing word, so
// unselected bytes are preserved.
// ---------------------------------------------------------------------------
module data_memory #(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              i_clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [3:0]        i_we,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [MEM_WORDS];
    logic [31:0] w_merged;

    assign o_rdata = r_mem[i_addr];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_merged[gi*8 +: 8] = i_we[gi] ? i_wdata[gi*8 +: 8] : o_rdata[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (|i_we) begin
            r_mem[i_addr] <= w_merged;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// MEM pipeline stage: owns the data memory, resolves BEQ/BNE and produces
// the MEM/WB pipeline register.
//   Clk, Rst (async, active high), Stall (freeze MEM/WB, block stores)
//   M_*          : EX/MEM register fields (controls, address, store data)
//   PCSrc        : branch taken (combinational)
//   BranchTarget : branch target (combinational passthrough)
//   W_*          : registered MEM/WB outputs
// Optional feature macro: MEM_SUBWORD_EN enables byte/half accesses with
// little-endian lanes. Without it every access is a full aligned word.
// ---------------------------------------------------------------------------
module mem_stage
    import mips_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic [3:0]  M_WB,
    input  logic        M_MemRead,
    input  logic        M_MemWrite,
    input  logic        M_Branch,
    input  logic        M_BNE,
    input  logic        M_ZeroFlag,
    input  logic [31:0] M_BranchAddResult,
    input  logic [31:0] M_ALUResult,
    input  logic [31:0] M_WriteMemData,
    input  logic [4:0]  M_WriteReg,
    input  logic [1:0]  M_MemSize,
    input  logic        M_MemSigned,
    output logic        PCSrc,
    output logic [31:0] BranchTarget,
    output logic [3:0]  W_WB,
    output logic [31:0] W_ReadData,
    output logic [31:0] W_ALUResult,
    output logic [4:0]  W_WriteReg
);

    logic [ADDR_W-1:0] w_word_idx;
    logic              w_store;
    logic [3:0]        w_we;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rdata;
    logic [31:0]       w_load;

    assign PCSrc        = M_Branch & (M_BNE ? ~M_ZeroFlag : M_ZeroFlag);
    assign BranchTarget = M_BranchAddResult;

    // Upper address bits are dropped so addresses wrap modulo the memory size.
    assign w_word_idx = M_ALUResult[ADDR_W+1:2];
    // Gating with Rst keeps a store coincident with reset assertion out of memory.
    assign w_store    = M_MemWrite & ~Stall & ~Rst;

`ifdef MEM_SUBWORD_EN
    logic [1:0]  w_off;
    logic [31:0] w_shift;

    // Misaligned halves/words are silently aligned down.
    always_comb begin
        w_off = 2'b00;
        case (M_MemSize)
            SZ_BYTE: w_off = M_ALUResult[1:0];
            SZ_HALF: w_off = {M_ALUResult[1], 1'b0};
            default: w_off = 2'b00;
        endcase
    end

    assign w_we = w_store ? lane_mask(M_MemSize, w_off) : 4'b0000;

    // Replicate the store data across lanes; the enables pick the right copy.
    always_comb begin
        w_wdata = M_WriteMemData;
        case (M_MemSize)
            SZ_BYTE: w_wdata = {4{M_WriteMemData[7:0]}};
            SZ_HALF: w_wdata = {2{M_WriteMemData[15:0]}};
            default: w_wdata = M_WriteMemData;
        endcase
    end

    assign w_shift = w_rdata >> {w_off, 3'b000};

    always_comb begin
        w_load = w_rdata;
        case (M_MemSize)
            SZ_BYTE: w_load = M_MemSigned ? {{24{w_shift[7]}}, w_shift[7:0]}
                                          : {24'h000000, w_shift[7:0]};
            SZ_HALF: w_load = M_MemSigned ? {{16{w_shift[15]}}, w_shift[15:0]}
                                          : {16'h0000, w_shift[15:0]};
            default: w_load = w_rdata;
        endcase
    end

    logic w_unused;
    assign w_unused = ^{M_ALUResult[31:ADDR_W+2]};
`else
    assign w_we    = {4{w_store}};
    assign w_wdata = M_WriteMemData;
    assign w_load  = w_rdata;

    logic w_unused;
    assign w_unused = ^{M_ALUResult[31:ADDR_W+2], M_ALUResult[1:0], M_MemSize, M_MemSigned};
`endif

    data_memory #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_dmem (
        .i_clk   (Clk),
        .i_addr  (w_word_idx),
        .i_we    (w_we),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // MEM/WB register. Load data is the pre-write word when a read and a
    // write coincide, because the read is combinational off the array.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            W_WB        <= 4'h0;
            W_ReadData  <= 32'h0;
            W_ALUResult <= 32'h0;
            W_WriteReg  <= 5'h0;
        end else if (!Stall) begin
            W_WB        <= M_WB;
            W_ReadData  <= M_MemRead ? w_load : 32'h0;
            W_ALUResult <= M_ALUResult;
            W_WriteReg  <= M_WriteReg;
        end
    end

endmodule
